// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the floating-point ALU request path.
package fp_alu_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [FP_W-1:0] FP_POS_ONE = 32'h3F80_0000;
   localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set req bit at or above ptr,
// wrapping to 0, wins. The rotation pointer itself belongs to the parent.
module fp_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gid,
   output logic            any_grant
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
      gid       = '0;
      any_grant = 1'b0;
      grant     = '0;
      // Walk from the farthest candidate back to ptr so the nearest set bit is written last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) begin
            gid       = IDW'(idx);
            any_grant = 1'b1;
         end
      end
      if (any_grant) grant = NREQ'(1) << gid;
   end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external combinational FP adder between NREQ requesters: round-robin
// grant, hold operands for ADD_LAT cycles, then return a tagged, backpressured response.
module fp_add_arbiter
   import fp_alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int ADD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [FP_W-1:0]      resp_s,
   output logic                 resp_overflow,
   output logic                 resp_underflow,
   output logic [FP_W-1:0]      add_a,
   output logic [FP_W-1:0]      add_b,
   input  logic [FP_W-1:0]      add_s,
   input  logic                 add_overflow,
   input  logic                 add_underflow,
   output logic                 busy
);

   localparam logic [3:0] CNT_LAST = 4'(ADD_LAT - 1);

   state_t           state, state_nx;
   logic [IDW-1:0]   ptr;
   logic [3:0]       cnt;
   logic [FP_W-1:0]  op_a, op_b;
   logic [IDW-1:0]   gid_q;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   gid;
   logic             any_grant;

   fp_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .gid       (gid),
      .any_grant (any_grant)
   );

   assign add_a = op_a;
   assign add_b = op_b;
   assign busy  = (state != IDLE);

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            // Masked during reset so nothing looks accepted while the state is being cleared.
            if (!rst) req_ready = grant;
            if (any_grant) state_nx = EXEC;
         end
         EXEC:    if (cnt == CNT_LAST) state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ptr            <= '0;
         cnt            <= '0;
         op_a           <= FP_ZERO;
         op_b           <= FP_ZERO;
         gid_q          <= '0;
         resp_valid     <= 1'b0;
         resp_id        <= '0;
         resp_s         <= FP_ZERO;
         resp_overflow  <= 1'b0;
         resp_underflow <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (any_grant) begin
               op_a  <= req_a[gid*FP_W +: FP_W];
               op_b  <= req_b[gid*FP_W +: FP_W];
               gid_q <= gid;
               ptr   <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
               cnt   <= '0;
            end
            EXEC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  resp_s         <= add_s;
                  resp_overflow  <= add_overflow;
                  resp_underflow <= add_underflow;
                  resp_id        <= gid_q;
                  resp_valid     <= 1'b1;
               end
            end
            RESP:    if (resp_ready) resp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
